// File: rtl/cdda_audio_out.sv
// cdda_audio_out -- CD-DA audio streamer on the AVR external SRAM bus.
//
// Firmware pushes 16-bit stereo PCM (little-endian, L then R) byte by byte
// into a FIFO. The block serialises one stereo frame every 1024 clk cycles.
// The output format is 64fs: BCK = clk/16 and LRCK = clk/1024, and each
// 16-bit sample is sent MSB first in slots 0-15 of its half-frame.
//
// Ports:
//   clk, rst         2x CPU clock (45.1584 MHz); synchronous active-high reset
//   sram_a/d_in/cs/oe/we   AVR SRAM-bus slave; 4-byte window at BASE_ADDR
//   sram_d_out       read data while selected and oe, else 0
//   sram_wait        always 0
//   irq              level refill request (IRQ_EN & EN & FIFO below half)
//   bck, lrck, sdat  serial audio outputs
//
// Register map (offset = sram_a[1:0]):
//   0 DATA   W push byte, R 0
//   1 STATUS R {UNDERRUN, OVF, full, empty, low, stg_valid, 2'b0}
//            W 1 to bit 7 / bit 6 clears the sticky flag
//   2 LEVEL  R min(count>>2, 255)
//   3 CTRL   R/W [0]EN [1]MUTE [2]FLUSH(self-clearing) [3]IRQ_EN
//
// Bus handshake: one CPU access holds sram_we for two clk cycles. The write
// acts only on the first clk of sel&sram_we (rising-edge detect). Reads are
// purely combinational and have no side effects.
module cdda_audio_out #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sram_a,
  input  logic [7:0]  sram_d_in,
  output logic [7:0]  sram_d_out,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic        sram_wait,
  output logic        irq,
  output logic        bck,
  output logic        lrck,
  output logic        sdat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------- bus decode ----------------
  logic       sel;
  logic [1:0] off;
  logic       wr_lvl, wr_q, wr_stb;
  logic       wr_data, wr_status, wr_ctrl, flush;

  assign sel       = sram_cs && (sram_a[15:2] == BASE_ADDR[15:2]);
  assign off       = sram_a[1:0];
  assign wr_lvl    = sel && sram_we;
  assign wr_stb    = wr_lvl && !wr_q;
  assign wr_data   = wr_stb && (off == 2'd0);
  assign wr_status = wr_stb && (off == 2'd1);
  assign wr_ctrl   = wr_stb && (off == 2'd3);
  assign flush     = wr_ctrl && sram_d_in[2];

  assign sram_wait = 1'b0;

  // ---------------- state ----------------
  logic          en_q, en_d, mute_q, mute_d, irq_en_q, irq_en_d;
  logic          under_q, under_d, ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          popping_q, popping_d;
  logic [1:0]    pop_idx_q, pop_idx_d;
  logic [31:0]   stg_q, stg_d;      // {R_hi, R_lo, L_hi, L_lo}
  logic          stg_valid_q, stg_valid_d;
  logic [31:0]   frame_q, frame_d;  // {R, L}
  logic [9:0]    cnt_q, cnt_d;
  logic          sdat_q, sdat_d;

  // ---------------- derived flags ----------------
  logic          full, empty, low, run;
  logic          push, pop, start_pop, frame_load;
  logic [1:0]    pidx;
  logic [10:0]   count_ext;
  logic [8:0]    level_raw;
  logic [7:0]    level;
  logic [7:0]    status;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign low       = (count_q < CW'(FIFO_DEPTH / 2));
  assign count_ext = 11'(count_q);
  assign level_raw = count_ext[10:2];
  assign level     = (level_raw > 9'd255) ? 8'hFF : level_raw[7:0];
  assign status    = {under_q, ovf_q, full, empty, low, stg_valid_q, 2'b00};

  // A push in the same cycle as FLUSH is discarded along with the contents.
  assign push      = wr_data && !full && !flush;

  // Staging refill: start once 4 bytes are available, then keep popping
  // one byte per cycle until the whole stereo frame has been taken.
  assign start_pop = en_q && !stg_valid_q && !popping_q && (count_q >= CW'(4));
  assign pop       = (popping_q || start_pop) && !flush;
  assign pidx      = popping_q ? pop_idx_q : 2'd0;

  // EN must be set both now and after this edge for the streamer to keep
  // running; a CTRL write clearing EN zeroes the phase on that same edge.
  assign en_d       = wr_ctrl ? sram_d_in[0] : en_q;
  assign mute_d     = wr_ctrl ? sram_d_in[1] : mute_q;
  assign irq_en_d   = wr_ctrl ? sram_d_in[3] : irq_en_q;
  assign run        = en_q && en_d;
  assign frame_load = run && (cnt_q == 10'd1023);

  // ---------------- next state ----------------
  logic [15:0] smp;
  logic        sbit;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    popping_d   = popping_q;
    pop_idx_d   = pop_idx_q;
    stg_d       = stg_q;
    stg_valid_d = stg_valid_q;
    frame_d     = frame_q;
    under_d     = under_q;
    ovf_d       = ovf_q;
    cnt_d       = run ? cnt_q + 10'd1 : 10'd0;

    if (wr_status && sram_d_in[7]) under_d = 1'b0;
    if (wr_status && sram_d_in[6]) ovf_d   = 1'b0;
    if (wr_data && full && !flush) ovf_d   = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      stg_d[{pidx, 3'b000} +: 8] = mem_q[rd_ptr_q];
      if (pidx == 2'd3) begin
        popping_d   = 1'b0;
        pop_idx_d   = 2'd0;
        stg_valid_d = 1'b1;
      end else begin
        popping_d = 1'b1;
        pop_idx_d = pidx + 2'd1;
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (frame_load) begin
      if (stg_valid_q) begin
        frame_d     = stg_q;
        stg_valid_d = 1'b0;
      end else begin
        frame_d = '0;
        under_d = 1'b1;
      end
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      popping_d   = 1'b0;
      pop_idx_d   = 2'd0;
      stg_valid_d = 1'b0;
    end
  end

  // Serial bit for the slot starting now: slot = cnt[8:4], bit 15-slot of
  // the current channel, zero in slots 16-31 and when muted.
  always_comb begin
    smp    = cnt_q[9] ? frame_q[31:16] : frame_q[15:0];
    sbit   = !cnt_q[8] && smp[~cnt_q[7:4]] && !mute_q;
    sdat_d = sdat_q;
    if (!run) sdat_d = 1'b0;
    else if (cnt_q[3:0] == 4'd0) sdat_d = sbit;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sram_d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      en_q        <= 1'b0;
      mute_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      under_q     <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      popping_q   <= 1'b0;
      pop_idx_q   <= 2'd0;
      stg_q       <= '0;
      stg_valid_q <= 1'b0;
      frame_q     <= '0;
      cnt_q       <= 10'd0;
      sdat_q      <= 1'b0;
    end else begin
      wr_q        <= wr_lvl;
      en_q        <= en_d;
      mute_q      <= mute_d;
      irq_en_q    <= irq_en_d;
      under_q     <= under_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      popping_q   <= popping_d;
      pop_idx_q   <= pop_idx_d;
      stg_q       <= stg_d;
      stg_valid_q <= stg_valid_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      sdat_q      <= sdat_d;
    end
  end

  // ---------------- outputs ----------------
  assign bck  = cnt_q[3];
  assign lrck = cnt_q[9];
  assign sdat = sdat_q;
  assign irq  = irq_en_q && en_q && low;

  always_comb begin
    sram_d_out = 8'h00;
    if (sel && sram_oe) begin
      case (off)
        2'd1:    sram_d_out = status;
        2'd2:    sram_d_out = level;
        2'd3:    sram_d_out = {4'b0000, irq_en_q, 1'b0, mute_q, en_q};
        default: sram_d_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cdda_audio_out.sv
module tb_cdda_audio_out;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 256;

  logic        clk, rst;
  logic [15:0] sram_a;
  logic [7:0]  sram_d_in, sram_d_out;
  logic        sram_cs, sram_oe, sram_we, sram_wait;
  logic        irq, bck, lrck, sdat;

  int n_vec = 0;
  int n_err = 0;

  // model of the FIFO contents while the streamer is stopped
  logic [7:0] fifo_m[$];
  logic       ovf_m;

  cdda_audio_out #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sram_a(sram_a), .sram_d_in(sram_d_in),
    .sram_d_out(sram_d_out), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_wait(sram_wait), .irq(irq), .bck(bck),
    .lrck(lrck), .sdat(sdat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1; sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    sram_a = 16'h0000; sram_d_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fifo_m.delete();
    ovf_m = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One CPU access: strobe held for 2 clk, then one idle clk.
  task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
    sram_a = BASE + {14'b0, off}; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
    @(negedge clk); @(negedge clk);
    sram_we = 1'b0; sram_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
    sram_a = BASE + {14'b0, off}; sram_cs = 1'b1; sram_oe = 1'b1;
    #1 d = sram_d_out;
    sram_cs = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus_write(2'd0, b);
    if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
    else ovf_m = 1'b1;
  endtask

  function automatic logic [7:0] model_status();
    int n;
    n = fifo_m.size();
    return {1'b0, ovf_m, n == DEPTH, n == 0, n < DEPTH / 2, 3'b000};
  endfunction

  function automatic logic [7:0] model_level();
    int l;
    l = fifo_m.size() / 4;
    return (l > 255) ? 8'hFF : 8'(l);
  endfunction

  // Leaves the bench at the first negedge of a new frame (phase 0).
  task automatic sync_frame;
    int t;
    t = 0;
    while (lrck !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    while (lrck !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL sync_frame: no lrck frame boundary within 3000 clk");
    end
  endtask

  // Records one 1024-clk frame starting at phase 0: the sdat bit at every
  // bck rising edge, how many rises, rises off the 16-clk grid, lrck-high
  // cycles and whether sdat was ever 1.
  task automatic capture_frame(output logic [63:0] word, output int rises,
                               output int off_grid, output int hi,
                               output bit any);
    logic pb;
    pb = bck; word = '0; rises = 0; off_grid = 0; hi = 0; any = 0;
    for (int i = 0; i < 1024; i++) begin
      if (bck && !pb) begin
        word = {word[62:0], sdat};
        rises++;
        if ((i % 16) != 8) off_grid++;
      end
      if (lrck) hi++;
      if (sdat) any = 1;
      pb = bck;
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return {b1, b0, 16'h0000, b3, b2, 16'h0000};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [7:0] d;
    do_reset;
    bus_read(2'd1, d);
    n_vec++; if (d !== 8'h18) begin n_err++; $display("FAIL reset_status: got %h expected 18", d); end
    bus_read(2'd2, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_level: got %h expected 00", d); end
    bus_read(2'd3, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00", d); end
    n_vec++;
    if ({bck, lrck, sdat, irq, sram_wait} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got bck/lrck/sdat/irq/wait=%b expected 00000",
                        {bck, lrck, sdat, irq, sram_wait});
    end
    // outside the window and unselected reads return 0
    sram_a = BASE + 16'd5; sram_cs = 1'b1; sram_oe = 1'b1;
    #1 d = sram_d_out;
    sram_cs = 1'b0; sram_oe = 1'b0;
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL read_outside: got %h expected 00", d); end
    @(negedge clk);
  endtask

  task automatic test_fifo;
    logic [7:0] d;
    do_reset;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    bus_read(2'd2, d);
    n_vec++; if (d !== model_level()) begin n_err++; $display("FAIL level_4: got %h expected %h", d, model_level()); end
    bus_read(2'd1, d);
    n_vec++; if (d !== model_status()) begin n_err++; $display("FAIL status_4: got %h expected %h", d, model_status()); end
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom_range(0, 255)));
    bus_read(2'd1, d);
    n_vec++; if (d !== model_status()) begin n_err++; $display("FAIL status_full: got %h expected %h", d, model_status()); end
    bus_read(2'd2, d);
    n_vec++; if (d !== model_level()) begin n_err++; $display("FAIL level_full: got %h expected %h", d, model_level()); end
    bus_read(2'd0, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL data_read: got %h expected 00", d); end
    bus_write(2'd1, 8'h40);
    ovf_m = 1'b0;
    bus_read(2'd1, d);
    n_vec++; if (d !== model_status()) begin n_err++; $display("FAIL ovf_clear: got %h expected %h", d, model_status()); end
    // FLUSH with MUTE and IRQ_EN, streamer stopped
    bus_write(2'd3, 8'h0E);
    fifo_m.delete();
    bus_read(2'd3, d);
    n_vec++; if (d !== 8'h0A) begin n_err++; $display("FAIL ctrl_read: got %h expected 0a", d); end
    bus_read(2'd1, d);
    n_vec++; if (d !== model_status()) begin n_err++; $display("FAIL status_flush: got %h expected %h", d, model_status()); end
    bus_write(2'd3, 8'h00);
  endtask

  task automatic test_stream;
    logic [7:0]  b[16];
    logic [63:0] w;
    logic [7:0]  d;
    int          rises, og, hi;
    bit          any;
    do_reset;
    b[0] = 8'h34; b[1] = 8'h12; b[2] = 8'hCD; b[3] = 8'hAB;
    for (int i = 4; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) bus_write(2'd0, b[i]);
    bus_write(2'd3, 8'h01);
    sync_frame;                        // frame 1 played the reset zeros
    capture_frame(w, rises, og, hi, any);
    n_vec++; if (w !== exp_word(b[0], b[1], b[2], b[3])) begin n_err++; $display("FAIL frame2_bits: got %h expected %h", w, exp_word(b[0], b[1], b[2], b[3])); end
    n_vec++; if (rises !== 64 || og !== 0) begin n_err++; $display("FAIL bck_period: got %0d rises %0d off-grid expected 64 0", rises, og); end
    n_vec++; if (hi !== 512) begin n_err++; $display("FAIL lrck_duty: got %0d high clk expected 512", hi); end
    // frame 3 is playing b[4..7]; refill while the staging is being drained
    for (int i = 8; i < 16; i++) bus_write(2'd0, b[i]);
    sync_frame;
    for (int f = 2; f < 4; f++) begin
      capture_frame(w, rises, og, hi, any);
      n_vec++;
      if (w !== exp_word(b[4*f], b[4*f+1], b[4*f+2], b[4*f+3])) begin
        n_err++; $display("FAIL frame%0d_bits: got %h expected %h", f + 2, w,
                          exp_word(b[4*f], b[4*f+1], b[4*f+2], b[4*f+3]));
      end
    end
    capture_frame(w, rises, og, hi, any);
    n_vec++; if (w !== 64'h0 || any !== 1'b0) begin n_err++; $display("FAIL underrun_frame: got %h any=%0d expected 0 0", w, any); end
    bus_read(2'd1, d);
    n_vec++; if (d[7] !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b expected 1", d[7]); end
    bus_write(2'd3, 8'h00);
  endtask

  task automatic test_underrun;
    logic [63:0] w;
    logic [7:0]  d;
    int          rises, og, hi;
    bit          any;
    do_reset;
    bus_write(2'd3, 8'h01);
    sync_frame;
    bus_read(2'd1, d);
    n_vec++; if (d[7] !== 1'b1) begin n_err++; $display("FAIL empty_underrun: got %b expected 1", d[7]); end
    capture_frame(w, rises, og, hi, any);
    n_vec++; if (any !== 1'b0) begin n_err++; $display("FAIL empty_sdat: got %0d expected 0", any); end
    bus_write(2'd3, 8'h00);
    bus_write(2'd1, 8'h80);
    bus_read(2'd1, d);
    n_vec++; if (d !== 8'h18) begin n_err++; $display("FAIL underrun_clear: got %h expected 18", d); end
  endtask

  task automatic test_irq;
    logic [7:0] d;
    int         falls, t;
    logic       pl;
    do_reset;
    for (int i = 0; i < 200; i++) bus_write(2'd0, 8'($urandom_range(0, 255)));
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    bus_write(2'd3, 8'h09);
    // 200 bytes, 4 taken by staging: 196, well above half
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_196: got %b expected 0", irq); end
    // each frame boundary takes 4 more; 196-4k drops below 128 at k=18
    falls = 0; t = 0; pl = lrck;
    while (irq !== 1'b1 && t < 25000) begin
      @(negedge clk); t++;
      if (pl && !lrck) falls++;
      pl = lrck;
    end
    n_vec++; if (falls !== 18) begin n_err++; $display("FAIL irq_frames: got %0d frames expected 18", falls); end
    bus_read(2'd2, d);
    n_vec++; if (d !== 8'd31) begin n_err++; $display("FAIL irq_level: got %0d expected 31", d); end
    bus_write(2'd3, 8'h0D);
    bus_read(2'd2, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL flush_level: got %h expected 00", d); end
    bus_read(2'd1, d);
    n_vec++; if ((d & 8'h3C) !== 8'h18) begin n_err++; $display("FAIL flush_status: got %h expected x0011000x", d); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL flush_irq: got %b expected 1", irq); end
    bus_read(2'd3, d);
    n_vec++; if (d !== 8'h09) begin n_err++; $display("FAIL flush_selfclear: got %h expected 09", d); end
    bus_write(2'd3, 8'h00);
  endtask

  task automatic test_disable_mute;
    logic [7:0] d;
    int         bad;
    do_reset;
    for (int i = 0; i < 16; i++) bus_write(2'd0, 8'($urandom_range(0, 255)));
    bus_write(2'd3, 8'h01);
    sync_frame;
    repeat (299) @(negedge clk);
    // 16 pushed, 4 to staging at enable, 4 more at the first frame boundary
    bus_read(2'd2, d);
    n_vec++; if (d !== 8'd2) begin n_err++; $display("FAIL level_running: got %0d expected 2", d); end
    n_vec++; if (bck !== 1'b1) begin n_err++; $display("FAIL bck_299: got %b expected 1", bck); end
    sram_a = BASE + 16'd3; sram_d_in = 8'h00; sram_cs = 1'b1; sram_we = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bck, lrck, sdat} !== 3'b000) begin
      n_err++; $display("FAIL disable_outputs: got bck/lrck/sdat=%b expected 000", {bck, lrck, sdat});
    end
    @(negedge clk);
    sram_we = 1'b0; sram_cs = 1'b0;
    repeat (2000) @(negedge clk);
    bus_read(2'd2, d);
    n_vec++; if (d !== 8'd2) begin n_err++; $display("FAIL level_kept: got %0d expected 2", d); end
    n_vec++; if ({bck, lrck} !== 2'b00) begin n_err++; $display("FAIL held_phase: got %b expected 00", {bck, lrck}); end
    // muted playback still consumes one frame (4 bytes) per boundary
    bus_write(2'd3, 8'h03);
    sync_frame;
    bad = 0;
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 1024; i++) begin
        if (sdat !== 1'b0) bad++;
        if (i == 8) begin
          bus_read(2'd2, d);
          n_vec++;
          if (d !== 8'((8 - 4 * k) / 4)) begin
            n_err++; $display("FAIL mute_level%0d: got %0d expected %0d", k, d, (8 - 4 * k) / 4);
          end
        end
        @(negedge clk);
      end
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mute_sdat: got %0d high cycles expected 0", bad); end
    bus_write(2'd3, 8'h00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    sram_a = 16'h0000; sram_d_in = 8'h00;
    test_reset;
    test_fifo;
    test_stream;
    test_underrun;
    test_irq;
    test_disable_mute;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
